memory_access: RTL and testbench

// - Memory stage of the 5-stage RV32I core; consumer of the execute stage outputs (ALU result, store data, PC+4, Rd).
// - Owns the EX/MEM pipeline register and the data-memory req/ack handshake; formats byte/half/word loads and stores.
// - Stalls upstream stages while an access is outstanding; presents one valid result per instruction to writeback.

---
 rtl/memory_access_pkg.sv | 25 ++
 rtl/memory_access_lsu_align.sv | 50 +++++
 rtl/memory_access.sv | 127 ++++++++++++
 tb/tb_memory_access.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared types and funct3 encodings for the memory stage
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // size is funct3[1:0]; the reserved size 2'b11 is handled like a word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return addr[0];
      default: return addr != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_lsu_align.sv
// rtl/memory_access_lsu_align.sv - byte-lane formatting for loads and stores
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // funct3[2] marks the unsigned load variants
  always_comb begin
    misalign_o = is_misaligned(funct3_i[1:0], addr_i);
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = funct3_i[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        be_o    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = funct3_i[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - RV32I memory stage: EX/MEM register, data-memory handshake, load/store formatting
module memory_access
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ValidE_i,
  input  logic                  FlushE_i,
  input  logic [DATA_WIDTH-1:0] ALUResultE_i,
  input  logic [DATA_WIDTH-1:0] WriteDataE_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
  input  logic [4:0]            RdE_i,
  input  logic                  RegWriteE_i,
  input  logic [1:0]            ResultSrcE_i,
  input  logic                  MemReadE_i,
  input  logic                  MemWriteE_i,
  input  logic [2:0]            MemCtrlE_i,
  output logic                  StallM_o,
  output logic                  DMemReq_o,
  output logic                  DMemWe_o,
  output logic [ADDR_WIDTH-1:0] DMemAddr_o,
  output logic [DATA_WIDTH-1:0] DMemWData_o,
  output logic [3:0]            DMemBe_o,
  input  logic [DATA_WIDTH-1:0] DMemRData_i,
  input  logic                  DMemAck_i,
  output logic                  ValidM_o,
  output logic [DATA_WIDTH-1:0] ALUResultM_o,
  output logic [DATA_WIDTH-1:0] ReadDataM_o,
  output logic [DATA_WIDTH-1:0] PCPlus4M_o,
  output logic [4:0]            RdM_o,
  output logic                  RegWriteM_o,
  output logic [1:0]            ResultSrcM_o,
  output logic                  MisalignM_o
);

  mem_state_t      state_q, state_d;
  logic            mvalid_q, regwrite_q, memread_q, memwrite_q;
  logic [31:0]     alu_q, wdata_q, pc4_q, rdata_q;
  logic [4:0]      rd_q;
  logic [1:0]      resultsrc_q;
  logic [2:0]      funct3_q;
  logic            capture, mvalid_d, in_req, misalign_m;
  logic [3:0]      be;
  logic [31:0]     wdata_rep, rdata_ext;
  logic            lsu_misalign;

  lsu_align u_lsu_align (
    .addr_i     (alu_q[1:0]),
    .funct3_i   (funct3_q),
    .wdata_i    (wdata_q),
    .rdata_i    (DMemRData_i),
    .be_o       (be),
    .wdata_o    (wdata_rep),
    .rdata_o    (rdata_ext),
    .misalign_o (lsu_misalign)
  );

  assign in_req   = (state_q == REQ);
  assign capture  = !in_req;
  assign mvalid_d = ValidE_i & ~FlushE_i;

  // Leaving IDLE or DONE is decided by what is being captured on this edge
  always_comb begin
    state_d = state_q;
    if (in_req) begin
      if (DMemAck_i) state_d = DONE;
    end else if (mvalid_d && (MemReadE_i || MemWriteE_i) &&
                 !is_misaligned(MemCtrlE_i[1:0], ALUResultE_i[1:0])) begin
      state_d = REQ;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mvalid_q    <= 1'b0;
      alu_q       <= '0;
      wdata_q     <= '0;
      pc4_q       <= '0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      resultsrc_q <= '0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      funct3_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        mvalid_q    <= mvalid_d;
        alu_q       <= ALUResultE_i;
        wdata_q     <= WriteDataE_i;
        pc4_q       <= PCPlus4E_i;
        rd_q        <= RdE_i;
        regwrite_q  <= RegWriteE_i;
        resultsrc_q <= ResultSrcE_i;
        memread_q   <= MemReadE_i;
        memwrite_q  <= MemWriteE_i;
        funct3_q    <= MemCtrlE_i;
      end
      if (in_req && DMemAck_i && memread_q) rdata_q <= rdata_ext;
    end
  end

  assign misalign_m   = mvalid_q & (memread_q | memwrite_q) & lsu_misalign;

  assign StallM_o     = in_req;
  assign DMemReq_o    = in_req;
  assign DMemWe_o     = in_req & memwrite_q;
  assign DMemAddr_o   = {alu_q[ADDR_WIDTH-1:2], 2'b00};
  assign DMemWData_o  = wdata_rep;
  assign DMemBe_o     = in_req ? be : 4'b0000;
  assign ValidM_o     = mvalid_q & ((state_q == IDLE) | (state_q == DONE));
  assign ALUResultM_o = alu_q;
  assign ReadDataM_o  = rdata_q;
  assign PCPlus4M_o   = pc4_q;
  assign RdM_o        = rd_q;
  assign RegWriteM_o  = mvalid_q & regwrite_q & ~misalign_m;
  assign ResultSrcM_o = resultsrc_q;
  assign MisalignM_o  = misalign_m;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - self-checking bench for memory_access with a byte-level reference model
module tb_memory_access;
  import mem_pkg::*;

  logic clk, rst_n;
  logic ValidE_i, FlushE_i, RegWriteE_i, MemReadE_i, MemWriteE_i, DMemAck_i;
  logic [31:0] ALUResultE_i, WriteDataE_i, PCPlus4E_i, DMemRData_i;
  logic [4:0] RdE_i;
  logic [1:0] ResultSrcE_i;
  logic [2:0] MemCtrlE_i;
  logic StallM_o, DMemReq_o, DMemWe_o, ValidM_o, RegWriteM_o, MisalignM_o;
  logic [31:0] DMemAddr_o, DMemWData_o, ALUResultM_o, ReadDataM_o, PCPlus4M_o;
  logic [3:0] DMemBe_o;
  logic [4:0] RdM_o;
  logic [1:0] ResultSrcM_o;

  int checks = 0;
  int errors = 0;

  memory_access #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ValidE_i(ValidE_i), .FlushE_i(FlushE_i),
    .ALUResultE_i(ALUResultE_i), .WriteDataE_i(WriteDataE_i), .PCPlus4E_i(PCPlus4E_i),
    .RdE_i(RdE_i), .RegWriteE_i(RegWriteE_i), .ResultSrcE_i(ResultSrcE_i),
    .MemReadE_i(MemReadE_i), .MemWriteE_i(MemWriteE_i), .MemCtrlE_i(MemCtrlE_i),
    .StallM_o(StallM_o), .DMemReq_o(DMemReq_o), .DMemWe_o(DMemWe_o), .DMemAddr_o(DMemAddr_o),
    .DMemWData_o(DMemWData_o), .DMemBe_o(DMemBe_o), .DMemRData_i(DMemRData_i),
    .DMemAck_i(DMemAck_i), .ValidM_o(ValidM_o), .ALUResultM_o(ALUResultM_o),
    .ReadDataM_o(ReadDataM_o), .PCPlus4M_o(PCPlus4M_o), .RdM_o(RdM_o),
    .RegWriteM_o(RegWriteM_o), .ResultSrcM_o(ResultSrcM_o), .MisalignM_o(MisalignM_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sizes, lanes and extension from plain arithmetic
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int b;
    b = ((1 << m_size(f3)) - 1) << int'(addr % 32'd4);
    return b[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (m_size(f3) == 1) return (d % 32'd256) * 32'h01010101;
    if (m_size(f3) == 2) return (d % 32'd65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v, mask;
    int bits;
    bits = 8 * m_size(f3);
    v = rd >> (8 * int'(addr % 32'd4));
    if (bits >= 32) return v;
    mask = (32'h1 << bits) - 32'h1;
    v = v & mask;
    if (f3 < 3'b100 && v >= (32'h1 << (bits - 1))) v = v | ~mask;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_e(input logic v, input logic fl, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                         input logic [1:0] rs, input logic mr, input logic mw, input logic [2:0] f3);
    ValidE_i = v; FlushE_i = fl; ALUResultE_i = alu; WriteDataE_i = wd; PCPlus4E_i = pc4;
    RdE_i = rd; RegWriteE_i = rw; ResultSrcE_i = rs; MemReadE_i = mr; MemWriteE_i = mw; MemCtrlE_i = f3;
  endtask

  task automatic bubble();
    drive_e(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; DMemAck_i = 1'b0; DMemRData_i = 32'h0;
    bubble();
    tick(); tick();
    checks++;
    if ({StallM_o, DMemReq_o, DMemWe_o, DMemAddr_o, DMemWData_o, DMemBe_o, ValidM_o, ALUResultM_o,
         ReadDataM_o, PCPlus4M_o, RdM_o, RegWriteM_o, ResultSrcM_o, MisalignM_o} !== '0) begin
      errors++; $display("FAIL reset_state: outputs not all zero (ReadDataM=%h Req=%b)", ReadDataM_o, DMemReq_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sw_latency3();
    drive_e(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h44, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 3'b010);
    tick(); bubble();
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({DMemReq_o, StallM_o, DMemWe_o, DMemAddr_o, DMemWData_o, DMemBe_o, ValidM_o} !==
          {3'b111, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0}) begin
        errors++; $display("FAIL sw_req_cycle%0d: req=%b stall=%b we=%b addr=%h wd=%h be=%b, want 1 1 1 100 deadbeef 1111",
                           c, DMemReq_o, StallM_o, DMemWe_o, DMemAddr_o, DMemWData_o, DMemBe_o);
      end
      if (c == 3) DMemAck_i = 1'b1;
      tick();
      DMemAck_i = 1'b0;
    end
    checks++;
    if ({ValidM_o, StallM_o, DMemReq_o, RegWriteM_o, MisalignM_o, PCPlus4M_o} !== {5'b10000, 32'h44}) begin
      errors++; $display("FAIL sw_done: valid=%b stall=%b req=%b pc4=%h, want 1 0 0 44", ValidM_o, StallM_o, DMemReq_o, PCPlus4M_o);
    end
    tick();
    checks++;
    if (ValidM_o !== 1'b0) begin errors++; $display("FAIL sw_single_valid: ValidM=%b want 0", ValidM_o); end
  endtask

  task automatic test_loads();
    logic [2:0] f3s [3] = '{3'b000, 3'b100, 3'b001};
    logic [31:0] addrs [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exps [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AA};
    for (int i = 0; i < 3; i++) begin
      drive_e(1'b1, 1'b0, addrs[i], 32'h0, 32'h200, 5'd7, 1'b1, 2'd1, 1'b1, 1'b0, f3s[i]);
      tick(); bubble();
      checks++;
      if ({DMemReq_o, StallM_o, DMemWe_o, DMemAddr_o} !== {3'b110, 32'h100}) begin
        errors++; $display("FAIL load%0d_req: req=%b stall=%b we=%b addr=%h want 1 1 0 100", i, DMemReq_o, StallM_o, DMemWe_o, DMemAddr_o);
      end
      DMemRData_i = 32'h80AABBCC; DMemAck_i = 1'b1;
      tick();
      DMemAck_i = 1'b0; DMemRData_i = $urandom;
      checks++;
      if ({ValidM_o, StallM_o, DMemReq_o, RegWriteM_o, RdM_o, ReadDataM_o} !== {4'b1001, 5'd7, exps[i]}) begin
        errors++; $display("FAIL load%0d_data: valid=%b stall=%b rw=%b rd=%0d data=%h want data %h", i, ValidM_o, StallM_o,
                           RegWriteM_o, RdM_o, ReadDataM_o, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_sb();
    drive_e(1'b1, 1'b0, 32'h102, 32'h000000A5, 32'h300, 5'd0, 1'b0, 2'd0, 1'b0, 1'b1, 3'b000);
    tick(); bubble();
    checks++;
    if ({DMemReq_o, DMemWe_o, DMemAddr_o, DMemWData_o, DMemBe_o} !== {2'b11, 32'h100, 32'hA5A5A5A5, 4'b0100}) begin
      errors++; $display("FAIL sb_format: req=%b we=%b addr=%h wd=%h be=%b want 1 1 100 a5a5a5a5 0100",
                         DMemReq_o, DMemWe_o, DMemAddr_o, DMemWData_o, DMemBe_o);
    end
    DMemAck_i = 1'b1;
    tick();
    DMemAck_i = 1'b0;
    checks++;
    if ({ValidM_o, ReadDataM_o} !== {1'b1, 32'hFFFF80AA}) begin
      errors++; $display("FAIL sb_done: valid=%b rdata=%h want 1 ffff80aa", ValidM_o, ReadDataM_o);
    end
    tick();
  endtask

  task automatic test_misalign();
    drive_e(1'b1, 1'b0, 32'h102, 32'h0, 32'h400, 5'd3, 1'b1, 2'd1, 1'b1, 1'b0, 3'b010);
    tick(); bubble();
    checks++;
    if ({DMemReq_o, StallM_o, ValidM_o, MisalignM_o, RegWriteM_o} !== 5'b00110) begin
      errors++; $display("FAIL lw_misalign: req=%b stall=%b valid=%b mis=%b rw=%b want 0 0 1 1 0",
                         DMemReq_o, StallM_o, ValidM_o, MisalignM_o, RegWriteM_o);
    end
    tick();
    checks++;
    if ({ValidM_o, MisalignM_o, DMemReq_o} !== 3'b000) begin
      errors++; $display("FAIL misalign_after: valid=%b mis=%b req=%b want 0 0 0", ValidM_o, MisalignM_o, DMemReq_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    prev = 32'h0;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        checks++;
        if ({ValidM_o, RegWriteM_o, ALUResultM_o, RdM_o} !== {2'b11, prev, 5'(i)}) begin
          errors++; $display("FAIL add%0d_valid: valid=%b rw=%b alu=%h rd=%0d want 1 1 %h %0d", i, ValidM_o, RegWriteM_o,
                             ALUResultM_o, RdM_o, prev, i);
        end
      end
      prev = $urandom;
      if (i < 4) drive_e(1'b1, 1'b0, prev, 32'h0, 32'h0, 5'(i + 1), 1'b1, 2'd0, 1'b0, 1'b0, 3'b000);
      else drive_e(1'b1, 1'b1, prev, 32'h0, 32'h0, 5'd9, 1'b1, 2'd0, 1'b0, 1'b0, 3'b000);
      tick();
    end
    checks++;
    if ({ValidM_o, RegWriteM_o} !== 2'b00) begin
      errors++; $display("FAIL flush_bubble: valid=%b rw=%b want 0 0", ValidM_o, RegWriteM_o);
    end
    drive_e(1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 5'd4, 1'b1, 2'd1, 1'b1, 1'b0, 3'b010);
    tick(); bubble(); FlushE_i = 1'b1;
    tick();
    checks++;
    if ({DMemReq_o, StallM_o, DMemAddr_o} !== {2'b11, 32'h200}) begin
      errors++; $display("FAIL flush_in_req: req=%b stall=%b addr=%h want 1 1 200", DMemReq_o, StallM_o, DMemAddr_o);
    end
    DMemRData_i = 32'h12345678; DMemAck_i = 1'b1;
    tick();
    DMemAck_i = 1'b0; FlushE_i = 1'b0;
    checks++;
    if ({ValidM_o, RegWriteM_o, ReadDataM_o} !== {2'b11, 32'h12345678}) begin
      errors++; $display("FAIL flush_req_completes: valid=%b rw=%b data=%h want 1 1 12345678", ValidM_o, RegWriteM_o, ReadDataM_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_request();
    drive_e(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 5'd2, 1'b1, 2'd1, 1'b1, 1'b0, 3'b010);
    tick(); bubble();
    checks++;
    if (DMemReq_o !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: req=%b want 1", DMemReq_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({StallM_o, DMemReq_o, DMemWe_o, DMemAddr_o, DMemWData_o, DMemBe_o, ValidM_o, ALUResultM_o,
         ReadDataM_o, PCPlus4M_o, RdM_o, RegWriteM_o, ResultSrcM_o, MisalignM_o} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: req=%b stall=%b addr=%h rdata=%h want all 0", DMemReq_o, StallM_o,
                         DMemAddr_o, ReadDataM_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({DMemReq_o, ValidM_o} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_idle: req=%b valid=%b want 0 0", DMemReq_o, ValidM_o);
    end
  endtask

  task automatic test_random();
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic pend, e_rw, e_mis, mr, mw, v, fl, rw;
    logic [31:0] e_alu, e_pc, last_load, alu, wd, pc, rdat;
    logic [4:0] e_rd, rd;
    logic [1:0] e_rs, rs;
    logic [2:0] f3;
    int kind, lat;
    pend = 1'b0; last_load = 32'h0;
    e_rw = 1'b0; e_mis = 1'b0; e_alu = '0; e_pc = '0; e_rd = '0; e_rs = '0;
    for (int i = 0; i <= 60; i++) begin
      checks++;
      if (pend) begin
        if ({ValidM_o, StallM_o, DMemReq_o, ALUResultM_o, PCPlus4M_o, RdM_o, RegWriteM_o, ResultSrcM_o, MisalignM_o, ReadDataM_o}
            !== {3'b100, e_alu, e_pc, e_rd, e_rw, e_rs, e_mis, last_load}) begin
          errors++; $display("FAIL rand%0d_result: valid=%b req=%b alu=%h rd=%0d rw=%b mis=%b data=%h want alu %h rd %0d rw %b mis %b data %h",
                             i, ValidM_o, DMemReq_o, ALUResultM_o, RdM_o, RegWriteM_o, MisalignM_o, ReadDataM_o,
                             e_alu, e_rd, e_rw, e_mis, last_load);
        end
      end else if ({ValidM_o, StallM_o, DMemReq_o, RegWriteM_o, MisalignM_o, ReadDataM_o} !== {5'b00000, last_load}) begin
        errors++; $display("FAIL rand%0d_bubble: valid=%b req=%b rw=%b mis=%b data=%h want 0 0 0 0 %h",
                           i, ValidM_o, DMemReq_o, RegWriteM_o, MisalignM_o, ReadDataM_o, last_load);
      end
      kind = (i == 60) ? 0 : int'($urandom_range(0, 3));
      alu = {$urandom_range(0, 32'h3FFF), 2'b00} + $urandom_range(0, 3);
      wd = $urandom; pc = $urandom; rd = 5'($urandom); rs = 2'($urandom); rw = 1'($urandom);
      v = 1'b1; fl = 1'b0; mr = 1'b0; mw = 1'b0; f3 = 3'($urandom);
      if (kind == 0) begin v = 1'($urandom); fl = v; mr = 1'($urandom); end
      if (kind == 2) begin mr = 1'b1; f3 = ld_f3[$urandom_range(0, 4)]; end
      if (kind == 3) begin mw = 1'b1; rw = 1'b0; f3 = 3'($urandom_range(0, 2)); end
      drive_e(v, fl, alu, wd, pc, rd, rw, rs, mr, mw, f3);
      DMemAck_i = 1'($urandom); DMemRData_i = $urandom;
      tick();
      DMemAck_i = 1'b0;
      bubble();
      pend = v & ~fl;
      e_alu = alu; e_pc = pc; e_rd = rd; e_rs = rs;
      e_mis = (mr | mw) & m_mis(f3, alu);
      e_rw = rw & ~e_mis;
      if (pend && (mr || mw) && !e_mis) begin
        lat = $urandom_range(1, 3);
        rdat = $urandom;
        for (int c = 1; c <= lat; c++) begin
          checks++;
          if ({DMemReq_o, StallM_o, ValidM_o, DMemWe_o, DMemAddr_o, DMemWData_o, DMemBe_o} !==
              {3'b110, mw, alu - (alu % 32'd4), m_wdata(f3, wd), m_be(f3, alu)}) begin
            errors++; $display("FAIL rand%0d_req%0d: req=%b we=%b addr=%h wd=%h be=%b want we %b addr %h wd %h be %b",
                               i, c, DMemReq_o, DMemWe_o, DMemAddr_o, DMemWData_o, DMemBe_o,
                               mw, alu - (alu % 32'd4), m_wdata(f3, wd), m_be(f3, alu));
          end
          DMemRData_i = (c == lat) ? rdat : $urandom;
          DMemAck_i = (c == lat);
          tick();
          DMemAck_i = 1'b0;
        end
        if (mr) last_load = m_load(f3, alu, rdat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_latency3();
    test_loads();
    test_sb();
    test_misalign();
    test_back_to_back();
    test_reset_mid_request();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
